// File: rtl/reg_block_master_pkg.sv
// Shared types and sizes for the register-bus initiator.
package reg_block_master_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 6;
    localparam int LEN_MAX = 64;
    localparam int CNT_W   = 7;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_STB,
        WR_GAP,
        RD_ADDR,
        RD_WAIT,
        RD_OUT
    } state_t;

    // A zero length field stands for the largest block, 64 quadlets.
    function automatic logic [CNT_W-1:0] len_decode(input logic [LEN_W-1:0] len);
        return (len == '0) ? CNT_W'(LEN_MAX) : {1'b0, len};
    endfunction

endpackage

// File: rtl/reg_block_master_if.sv
// Request, write-data, read-data and register-file signals of the initiator.
// master = the initiator itself, slave = packet layer plus responder side.
interface reg_block_master_if;
    import reg_block_master_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              req_incr;

    logic              wdat_valid;
    logic              wdat_ready;
    logic [DATA_W-1:0] wdat;

    logic              rdat_valid;
    logic              rdat_ready;
    logic [DATA_W-1:0] rdat;
    logic              rdat_last;

    logic              busy;

    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              wr_en;
    logic [DATA_W-1:0] reg_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_len, req_incr,
        input  wdat_valid, wdat, rdat_ready, reg_rdata,
        output req_ready, wdat_ready, rdat_valid, rdat, rdat_last, busy,
        output reg_addr, reg_wdata, wr_en
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, req_incr,
        output wdat_valid, wdat, rdat_ready, reg_rdata,
        input  req_ready, wdat_ready, rdat_valid, rdat, rdat_last, busy,
        input  reg_addr, reg_wdata, wr_en
    );

endinterface

// File: rtl/reg_block_master.sv
// Register-bus initiator: turns quadlet/block requests into one-cycle write
// strobes and latency-matched register reads, with optional address increment.
module reg_block_master
    import reg_block_master_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int GAP    = 1
) (
    input  logic               sysclk,
    input  logic               reset,
    reg_block_master_if.master bus
);

    // Gap counter starts at GAP-1 so WR_GAP lasts exactly GAP cycles; the read
    // wait runs RD_LAT+1 cycles so the responder's registered data has settled
    // a full cycle before we capture it.
    localparam logic [1:0] GAP_LOAD = 2'(GAP - 1);
    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        lat_cnt;
    logic [1:0]        gap_cnt;
    logic              incr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdat_q;

    logic req_ready_c;
    logic wdat_ready_c;
    logic wr_en_c;
    logic rdat_valid_c;
    logic rdat_last_c;
    logic busy_c;
    logic accept;

    assign accept = bus.req_valid & req_ready_c;

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge sysclk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state sequencing of write and read quadlets.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = bus.req_write ? WR_WAIT : RD_ADDR;
            WR_WAIT: if (bus.wdat_valid) state_nxt = WR_STB;
            WR_STB:  state_nxt = WR_GAP;
            WR_GAP:  if (gap_cnt == '0) state_nxt = (cnt != '0) ? WR_WAIT : IDLE;
            RD_ADDR: state_nxt = RD_WAIT;
            RD_WAIT: if (lat_cnt == '0) state_nxt = RD_OUT;
            RD_OUT:  if (bus.rdat_ready) state_nxt = (cnt == CNT_W'(1)) ? IDLE : RD_ADDR;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state; ready is held off while
    // reset is asserted.
    always_comb begin
        req_ready_c  = 1'b0;
        wdat_ready_c = 1'b0;
        wr_en_c      = 1'b0;
        rdat_valid_c = 1'b0;
        rdat_last_c  = 1'b0;
        busy_c       = (state != IDLE);
        case (state)
            IDLE:    req_ready_c  = reset;
            WR_WAIT: wdat_ready_c = 1'b1;
            WR_STB:  wr_en_c      = 1'b1;
            RD_OUT: begin
                rdat_valid_c = 1'b1;
                rdat_last_c  = (cnt == CNT_W'(1));
            end
            default: ;
        endcase
    end

    // Address, data and counters; the address only moves on leaving WR_GAP or
    // RD_OUT so it is never disturbed under a strobe or a pending read.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdat_q  <= '0;
            cnt     <= '0;
            incr_q  <= 1'b0;
            lat_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    addr_q <= bus.req_addr;
                    cnt    <= len_decode(bus.req_len);
                    incr_q <= bus.req_incr;
                end
                WR_WAIT: if (bus.wdat_valid) wdata_q <= bus.wdat;
                WR_STB: begin
                    cnt     <= cnt - CNT_W'(1);
                    gap_cnt <= GAP_LOAD;
                end
                WR_GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - 2'd1;
                    else if (incr_q)   addr_q  <= addr_q + ADDR_W'(1);
                end
                RD_ADDR: lat_cnt <= LAT_LOAD;
                RD_WAIT: begin
                    if (lat_cnt != '0) lat_cnt <= lat_cnt - 3'd1;
                    else               rdat_q  <= bus.reg_rdata;
                end
                RD_OUT: if (bus.rdat_ready) begin
                    cnt <= cnt - CNT_W'(1);
                    if (incr_q) addr_q <= addr_q + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.wdat_ready = wdat_ready_c;
    assign bus.wr_en      = wr_en_c;
    assign bus.rdat_valid = rdat_valid_c;
    assign bus.rdat_last  = rdat_last_c;
    assign bus.busy       = busy_c;
    assign bus.reg_addr   = addr_q;
    assign bus.reg_wdata  = wdata_q;
    assign bus.rdat       = rdat_q;

endmodule

// File: tb/tb_reg_block_master.sv
// Bench for reg_block_master: transaction-level model of expected strobes and
// read quadlets, a registered responder, and a per-cycle compare process.
module tb_reg_block_master;
    import reg_block_master_pkg::*;

    localparam int RD_LAT = 1;
    localparam int GAP    = 1;

    logic sysclk = 1'b0;
    logic reset  = 1'b0;
    always #5 sysclk = ~sysclk;

    reg_block_master_if bus();

    reg_block_master #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [7:0] addr; logic [31:0] data; logic last; } rd_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic rst_q  = 1'b1;

    wr_t exp_wr[$];
    wr_t got_wr[$];
    rd_t exp_rd[$];
    rd_t got_rd[$];

    logic [31:0] model_mem [256];
    logic [31:0] resp_mem  [256];
    logic [31:0] rd_pipe   [RD_LAT];

    int wr_prev_cyc  = -1;
    int wd_hs_cyc    = -1;
    int busy_chk_cyc = -1;
    int rd_ref       = 0;

    always @(posedge sysclk) cyc   <= cyc + 1;
    always @(posedge sysclk) rst_q <= reset;

    // Responder: writes on the strobe, read data registered RD_LAT edges after the address.
    always @(posedge sysclk) begin
        rd_pipe[0] <= resp_mem[bus.reg_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (bus.wr_en) resp_mem[bus.reg_addr] = bus.reg_wdata;
    end
    assign bus.reg_rdata = rd_pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input int a);
        logic [7:0] b;
        b = 8'(a);
        return (b == 8'h04) ? 32'h514C_4131 : {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    // Per-cycle compare against the expectation queues and the timing rules.
    logic        prev_wr_en = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_wdata = '0;
    logic [31:0] prev_rdat  = '0;
    logic [7:0]  prev_raddr = '0;
    always @(negedge sysclk) begin
        if (!rst_q) begin
            chk("rst_wr_en",      32'(bus.wr_en), 0);
            chk("rst_busy",       32'(bus.busy), 0);
            chk("rst_wdat_ready", 32'(bus.wdat_ready), 0);
            chk("rst_rdat_valid", 32'(bus.rdat_valid), 0);
            chk("rst_rdat_last",  32'(bus.rdat_last), 0);
            chk("rst_rdat",       bus.rdat, 0);
            chk("rst_reg_addr",   32'(bus.reg_addr), 0);
            chk("rst_reg_wdata",  bus.reg_wdata, 0);
            if (!reset) chk("rst_req_ready", 32'(bus.req_ready), 0);
            prev_wr_en = 1'b0;
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (bus.wr_en) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_wr_en", 32'(bus.wr_en), 0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(bus.reg_addr), 32'(e.addr));
                    chk("wr_data", bus.reg_wdata, e.data);
                    got_wr.push_back('{bus.reg_addr, bus.reg_wdata});
                    if (wr_prev_cyc >= 0) chk("wr_period", 32'(cyc - wr_prev_cyc), 32'(2 + GAP));
                    chk("wr_after_wdat", 32'(cyc), 32'(wd_hs_cyc + 1));
                    wr_prev_cyc = cyc;
                    if (exp_wr.size() == 0) busy_chk_cyc = cyc;
                end
                if (prev_wr_en) chk("wr_en_width", 32'(bus.wr_en), 0);
            end
            if (prev_wr_en) chk("wdata_hold", bus.reg_wdata, prev_wdata);
            if (busy_chk_cyc >= 0 && cyc == busy_chk_cyc + GAP) chk("busy_in_gap", 32'(bus.busy), 1);
            if (busy_chk_cyc >= 0 && cyc == busy_chk_cyc + GAP + 1) begin
                chk("busy_after_write", 32'(bus.busy), 0);
                busy_chk_cyc = -1;
            end
            if (bus.wdat_valid && bus.wdat_ready) wd_hs_cyc = cyc;

            if (bus.rdat_valid) begin
                if (!prev_valid) chk("rd_latency", 32'(cyc), 32'(rd_ref));
                if (prev_stall) begin
                    chk("rdat_hold", bus.rdat, prev_rdat);
                    chk("raddr_hold", 32'(bus.reg_addr), 32'(prev_raddr));
                end
                if (exp_rd.size() == 0) begin
                    chk("unexpected_rdat_valid", 32'(bus.rdat_valid), 0);
                end else begin
                    chk("rd_data", bus.rdat, exp_rd[0].data);
                    chk("rd_last", 32'(bus.rdat_last), 32'(exp_rd[0].last));
                    chk("rd_addr", 32'(bus.reg_addr), 32'(exp_rd[0].addr));
                    if (bus.rdat_ready) begin
                        void'(exp_rd.pop_front());
                        got_rd.push_back('{bus.reg_addr, bus.rdat, bus.rdat_last});
                        rd_ref = cyc + 3 + RD_LAT;
                    end
                end
            end
            prev_wr_en = bus.wr_en;
            prev_wdata = bus.reg_wdata;
            prev_valid = bus.rdat_valid;
            prev_stall = bus.rdat_valid & ~bus.rdat_ready;
            prev_rdat  = bus.rdat;
            prev_raddr = bus.reg_addr;
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [7:0] a, input logic [5:0] l,
                         input logic inc, output int acc);
        int guard;
        guard = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_len   = l;
        bus.req_incr  = inc;
        while (!bus.req_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!bus.req_ready) begin
            chk("req_accept_timeout", 32'(bus.req_ready), 1);
            bus.req_valid = 1'b0;
            acc = -1;
            return;
        end
        tick();
        acc = cyc;
        bus.req_valid = 1'b0;
        bus.req_addr  = ~a;
        bus.req_len   = 6'h2A;
        bus.req_incr  = ~inc;
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while ((bus.busy || exp_rd.size() != 0) && guard < 1000) begin
            tick();
            guard++;
        end
        if (bus.busy) chk(name, 32'(bus.busy), 0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [5:0] l, input logic inc,
                            input logic [31:0] base, input logic abort);
        int n, acc, guard;
        logic [7:0] ad;
        n = (l == 0) ? 64 : int'(l);
        for (int i = 0; i < n; i++) begin
            ad = inc ? a + 8'(i) : a;
            exp_wr.push_back('{ad, base + 32'(i)});
        end
        issue(1'b1, a, l, inc, acc);
        if (acc < 0) return;
        wr_prev_cyc = -1;
        for (int i = 0; i < n; i++) begin
            ad = inc ? a + 8'(i) : a;
            bus.wdat       = base + 32'(i);
            bus.wdat_valid = 1'b1;
            guard = 0;
            while (!bus.wdat_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (!bus.wdat_ready) begin
                chk("wdat_timeout", 32'(bus.wdat_ready), 1);
                return;
            end
            model_mem[ad] = base + 32'(i);
            tick();
            if (abort) begin
                tick();
                exp_wr.delete();
                bus.wdat_valid = 1'b0;
                reset = 1'b0;
                return;
            end
        end
        bus.wdat = 32'hDEAD_BEEF;
        wait_idle("write_busy_timeout");
        repeat (3) tick();
        bus.wdat_valid = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [5:0] l, input logic inc,
                           input logic stall);
        int n, acc, guard;
        logic [7:0] ad;
        n = (l == 0) ? 64 : int'(l);
        for (int i = 0; i < n; i++) begin
            ad = inc ? a + 8'(i) : a;
            exp_rd.push_back('{ad, model_mem[ad], (i == n - 1)});
        end
        bus.rdat_ready = ~stall;
        issue(1'b0, a, l, inc, acc);
        if (acc < 0) return;
        rd_ref = acc + 2 + RD_LAT;
        if (stall) begin
            guard = 0;
            while (!bus.rdat_valid && guard < 50) begin
                tick();
                guard++;
            end
            repeat (5) tick();
            bus.rdat_ready = 1'b1;
        end
        wait_idle("read_busy_timeout");
        chk("rd_all_delivered", 32'(exp_rd.size()), 0);
        exp_rd.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) begin
            model_mem[a] = init_val(a);
            resp_mem[a]  = init_val(a);
        end
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_len    = '0;
        bus.req_incr   = 1'b0;
        bus.wdat_valid = 1'b0;
        bus.wdat       = '0;
        bus.rdat_ready = 1'b1;

        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("ready_after_reset", 32'(bus.req_ready), 1);
        chk("idle_after_reset", 32'(bus.busy), 0);

        // single write
        got_wr.delete();
        do_write(8'h03, 6'd1, 1'b1, 32'h0000_1234, 1'b0);
        chk("single_wr_count", 32'(got_wr.size()), 1);
        if (got_wr.size() == 1) begin
            chk("single_wr_addr", 32'(got_wr[0].addr), 32'h03);
            chk("single_wr_data", got_wr[0].data, 32'h0000_1234);
        end

        // block write with wrap-around
        got_wr.delete();
        do_write(8'hFE, 6'd3, 1'b1, 32'hA000_0000, 1'b0);
        chk("blk_wr_count", 32'(got_wr.size()), 3);
        if (got_wr.size() == 3) begin
            chk("blk_wr_addr0", 32'(got_wr[0].addr), 32'hFE);
            chk("blk_wr_addr1", 32'(got_wr[1].addr), 32'hFF);
            chk("blk_wr_addr2", 32'(got_wr[2].addr), 32'h00);
        end

        // fixed-address block read
        got_rd.delete();
        do_read(8'h04, 6'd2, 1'b0, 1'b0);
        chk("fix_rd_count", 32'(got_rd.size()), 2);
        if (got_rd.size() == 2) begin
            chk("fix_rd_data0", got_rd[0].data, 32'h514C_4131);
            chk("fix_rd_data1", got_rd[1].data, 32'h514C_4131);
            chk("fix_rd_last0", 32'(got_rd[0].last), 0);
            chk("fix_rd_last1", 32'(got_rd[1].last), 1);
            chk("fix_rd_addr1", 32'(got_rd[1].addr), 32'h04);
        end

        // backpressure on the first quadlet
        got_rd.delete();
        do_read(8'h30, 6'd2, 1'b1, 1'b1);
        chk("bp_rd_count", 32'(got_rd.size()), 2);
        if (got_rd.size() == 2) begin
            chk("bp_rd_data0", got_rd[0].data, 32'h30CF_6AC3);
            chk("bp_rd_addr1", 32'(got_rd[1].addr), 32'h31);
        end

        // read back the wrapped block write
        got_rd.delete();
        do_read(8'hFE, 6'd3, 1'b1, 1'b0);
        chk("rb_count", 32'(got_rd.size()), 3);
        if (got_rd.size() == 3) begin
            chk("rb_data0", got_rd[0].data, 32'hA000_0000);
            chk("rb_data2", got_rd[2].data, 32'hA000_0002);
        end

        // len 0 means 64 quadlets
        got_rd.delete();
        do_read(8'hC0, 6'd0, 1'b1, 1'b0);
        chk("len0_count", 32'(got_rd.size()), 64);
        if (got_rd.size() == 64) begin
            chk("len0_last62", 32'(got_rd[62].last), 0);
            chk("len0_last63", 32'(got_rd[63].last), 1);
            chk("len0_addr63", 32'(got_rd[63].addr), 32'hFF);
        end

        // reset in the gap after the first strobe of a 4-quadlet write
        got_wr.delete();
        do_write(8'h20, 6'd4, 1'b1, 32'h5555_0000, 1'b1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("ready_after_abort", 32'(bus.req_ready), 1);
        chk("idle_after_abort", 32'(bus.busy), 0);
        repeat (10) tick();
        chk("abort_wr_count", 32'(got_wr.size()), 1);
        if (got_wr.size() == 1) chk("abort_wr_addr", 32'(got_wr[0].addr), 32'h20);

        // recovery: new write then read the abandoned range
        do_write(8'h22, 6'd1, 1'b0, 32'h0000_CAFE, 1'b0);
        got_rd.delete();
        do_read(8'h20, 6'd4, 1'b1, 1'b0);
        if (got_rd.size() == 4) begin
            chk("recov_data0", got_rd[0].data, 32'h5555_0000);
            chk("recov_data1", got_rd[1].data, 32'h21DE_7BC3);
            chk("recov_data2", got_rd[2].data, 32'h0000_CAFE);
        end else begin
            chk("recov_count", 32'(got_rd.size()), 4);
        end

        repeat (5) tick();
        chk("no_pending_writes", 32'(exp_wr.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
